// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: drives the predictor table read port at fetch time,
// keeps in-flight branch predictions in an in-order queue, checks each one
// against the outcome resolved in EX, flushes and redirects on a mispredict,
// and issues the table write one cycle after each resolve.
// The table's counter next-state is read from the entry at the read address,
// so the read port is pointed at the write index during the write cycle.
// Optional feature: define BRU_STATS_EN to add saturating branch and
// mispredict counters (o_br_count, o_mispred_count).
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_fetch_valid,
    input  logic             i_fetch_branch,
    input  logic [29:0]      i_fetch_pc,
    input  logic [30:0]      i_pred_data,
    output logic [IDX_W-1:0] o_rd_addr,
    output logic [29:0]      o_pred_next_pc,
    output logic             o_fetch_stall,
    input  logic             i_res_valid,
    input  logic             i_res_taken,
    input  logic [29:0]      i_res_target,
    output logic             o_res_ready,
    output logic             o_flush,
    output logic [29:0]      o_redirect_pc,
    output logic             o_we,
    output logic [IDX_W-1:0] o_wr_addr,
    output logic [29:0]      o_wr_data,
`ifdef BRU_STATS_EN
    output logic [15:0]      o_br_count,
    output logic [15:0]      o_mispred_count,
`endif
    output logic             o_next
);

    // state  | meaning
    // IDLE   | predicting, pushing, accepting resolves
    // UPDATE | table write cycle; fetch stalled, no push, no resolve

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

    state_t           state_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW:0]      count_q, count_d;
    logic [29:0]      q_pc_q  [DEPTH];
    logic [29:0]      q_tgt_q [DEPTH];
    logic             q_tkn_q [DEPTH];

    logic             we_q;
    logic             flush_q;
    logic [29:0]      redirect_q;
    logic [IDX_W-1:0] upd_addr_q;
    logic [29:0]      upd_data_q;
    logic             upd_next_q;

    logic [29:0]      head_pc, head_tgt;
    logic             head_tkn;
    logic             full, empty, push, accept, mispredict, squash;

    assign head_pc  = q_pc_q[head_q];
    assign head_tgt = q_tgt_q[head_q];
    assign head_tkn = q_tkn_q[head_q];

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign o_fetch_stall = (state_q == UPDATE) | (full & i_fetch_valid & i_fetch_branch);
    assign o_res_ready   = (state_q == IDLE) & ~empty;

    assign push       = i_fetch_valid & i_fetch_branch & ~o_fetch_stall;
    assign accept     = i_res_valid & o_res_ready;
    // Direction mismatch, or both taken but to different targets.
    assign mispredict = (head_tkn != i_res_taken) |
                        (head_tkn & i_res_taken & (head_tgt != i_res_target));
    assign squash     = accept & mispredict;

    assign o_rd_addr      = (state_q == UPDATE) ? upd_addr_q : i_fetch_pc[IDX_W-1:0];
    assign o_pred_next_pc = i_pred_data[0] ? i_pred_data[30:1] : i_fetch_pc + 30'd1;

    assign o_we          = we_q;
    assign o_flush       = flush_q;
    assign o_redirect_pc = redirect_q;
    assign o_wr_addr     = upd_addr_q;
    assign o_wr_data     = upd_data_q;
    assign o_next        = upd_next_q;

    // Queue pointer/occupancy next-state; a mispredict discards everything, including a same-cycle push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (accept) head_d = head_q + 1'b1;
            if (push)   tail_d = tail_q + 1'b1;
            count_d = count_q + (PW+1)'(push) - (PW+1)'(accept);
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge Clk) begin
        if (push && !squash) begin
            q_pc_q[tail_q]  <= i_fetch_pc;
            q_tgt_q[tail_q] <= i_pred_data[30:1];
            q_tkn_q[tail_q] <= i_pred_data[0];
        end
    end

    // Resolve FSM with registered flush/redirect and table-write outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            upd_addr_q <= '0;
            upd_data_q <= '0;
            upd_next_q <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= UPDATE;
                        we_q       <= 1'b1;
                        upd_addr_q <= head_pc[IDX_W-1:0];
                        upd_next_q <= i_res_taken;
                        upd_data_q <= i_res_taken ? i_res_target : head_tgt;
                        if (mispredict) begin
                            flush_q    <= 1'b1;
                            redirect_q <= i_res_taken ? i_res_target : head_pc + 30'd1;
                        end
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] br_count_q, mispred_count_q;

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (accept && br_count_q != 16'hFFFF)
                br_count_q <= br_count_q + 16'd1;
            if (squash && mispred_count_q != 16'hFFFF)
                mispred_count_q <= mispred_count_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios with constant
// expectations plus a randomized run checked against a queue-based model.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        i_fetch_valid = 1'b0, i_fetch_branch = 1'b0;
    logic [29:0] i_fetch_pc = '0;
    logic [30:0] i_pred_data = '0;
    logic        i_res_valid = 1'b0, i_res_taken = 1'b0;
    logic [29:0] i_res_target = '0;
    logic [4:0]  o_rd_addr, o_wr_addr;
    logic [29:0] o_pred_next_pc, o_redirect_pc, o_wr_data;
    logic        o_fetch_stall, o_res_ready, o_flush, o_we, o_next;
`ifdef BRU_STATS_EN
    logic [15:0] o_br_count, o_mispred_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .i_fetch_valid(i_fetch_valid), .i_fetch_branch(i_fetch_branch),
        .i_fetch_pc(i_fetch_pc), .i_pred_data(i_pred_data),
        .o_rd_addr(o_rd_addr), .o_pred_next_pc(o_pred_next_pc), .o_fetch_stall(o_fetch_stall),
        .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
        .o_res_ready(o_res_ready), .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
        .o_we(o_we), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
`ifdef BRU_STATS_EN
        .o_br_count(o_br_count), .o_mispred_count(o_mispred_count),
`endif
        .o_next(o_next)
    );

    task automatic set_in(input logic fv, input logic fb, input logic [29:0] pc, input logic [30:0] pd,
                          input logic rv, input logic rtk, input logic [29:0] rtg);
        i_fetch_valid  = fv;
        i_fetch_branch = fb;
        i_fetch_pc     = pc;
        i_pred_data    = pd;
        i_res_valid    = rv;
        i_res_taken    = rtk;
        i_res_target   = rtg;
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        set_in(0, 0, '0, '0, 0, 0, '0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        apply_reset();
        set_in(1, 0, 30'h1ABC, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", o_we); end
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b exp 0", o_flush); end
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", o_res_ready); end
        n_cmp++; if (o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", o_fetch_stall); end
        n_cmp++; if (o_rd_addr !== 5'h1C) begin n_fail++; $display("FAIL rst_rd_addr got %h exp 1c", o_rd_addr); end
        @(negedge Clk);
        // Mispredicting resolve, then reset asserted in the middle of the UPDATE cycle.
        set_in(1, 1, 30'h7, {30'h0, 1'b0}, 0, 0, '0);
        @(negedge Clk);
        set_in(0, 0, '0, '0, 1, 1, 30'h300);
        #1;
        n_cmp++; if (o_res_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_pre got %b exp 1", o_res_ready); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_pre got %b exp 1", o_we); end
        #1 Reset = 1'b0;
        #1;
        n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b exp 0", o_we); end
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL midrst_flush got %b exp 0", o_flush); end
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", o_res_ready); end
        @(negedge Clk);
        Reset = 1'b1;
        set_in(1, 1, 30'h8, {30'h0, 1'b0}, 0, 0, '0);
        #1;
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL postrst_empty got %b exp 0", o_res_ready); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_res_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_ready got %b exp 1", o_res_ready); end
        @(negedge Clk);
    endtask

    task automatic test_correct();
        apply_reset();
        set_in(1, 1, 30'h100, {30'h200, 1'b1}, 0, 0, '0);
        #1;
        n_cmp++; if (o_pred_next_pc !== 30'h200) begin n_fail++; $display("FAIL corr_pred got %h exp 200", o_pred_next_pc); end
        n_cmp++; if (o_rd_addr !== 5'h00) begin n_fail++; $display("FAIL corr_rd got %h exp 00", o_rd_addr); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 1, 1, 30'h200);
        #1;
        n_cmp++; if (o_res_ready !== 1'b1) begin n_fail++; $display("FAIL corr_ready got %b exp 1", o_res_ready); end
        @(negedge Clk);
        set_in(1, 1, 30'h155, {30'h0, 1'b0}, 0, 0, '0);
        #1;
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL corr_flush got %b exp 0", o_flush); end
        n_cmp++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL corr_we got %b exp 1", o_we); end
        n_cmp++; if (o_rd_addr !== 5'h00) begin n_fail++; $display("FAIL corr_upd_rd got %h exp 00", o_rd_addr); end
        n_cmp++; if (o_wr_addr !== 5'h00) begin n_fail++; $display("FAIL corr_wr_addr got %h exp 00", o_wr_addr); end
        n_cmp++; if (o_wr_data !== 30'h200) begin n_fail++; $display("FAIL corr_wr_data got %h exp 200", o_wr_data); end
        n_cmp++; if (o_next !== 1'b1) begin n_fail++; $display("FAIL corr_next got %b exp 1", o_next); end
        n_cmp++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL corr_stall got %b exp 1", o_fetch_stall); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL corr_we_drop got %b exp 0", o_we); end
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL corr_no_push_in_upd got %b exp 0", o_res_ready); end
        @(negedge Clk);
    endtask

    task automatic test_mispredict();
        apply_reset();
        set_in(1, 1, 30'h105, {30'h0, 1'b0}, 0, 0, '0);
        @(negedge Clk);
        set_in(1, 1, 30'h106, {30'h0, 1'b0}, 1, 1, 30'h300);
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %b exp 1", o_flush); end
        n_cmp++; if (o_redirect_pc !== 30'h300) begin n_fail++; $display("FAIL mis_redirect got %h exp 300", o_redirect_pc); end
        n_cmp++; if (o_we !== 1'b1) begin n_fail++; $display("FAIL mis_we got %b exp 1", o_we); end
        n_cmp++; if (o_wr_addr !== 5'h05) begin n_fail++; $display("FAIL mis_wr_addr got %h exp 05", o_wr_addr); end
        n_cmp++; if (o_wr_data !== 30'h300) begin n_fail++; $display("FAIL mis_wr_data got %h exp 300", o_wr_data); end
        @(negedge Clk);
        #1;
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL mis_flush_pulse got %b exp 0", o_flush); end
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL mis_queue_empty got %b exp 0", o_res_ready); end
        @(negedge Clk);
    endtask

    task automatic test_wrap();
        apply_reset();
        set_in(1, 0, 30'h3FFFFFFF, {30'h1234, 1'b0}, 0, 0, '0);
        #1;
        n_cmp++; if (o_pred_next_pc !== 30'h0) begin n_fail++; $display("FAIL wrap_pred got %h exp 0", o_pred_next_pc); end
        @(negedge Clk);
        set_in(1, 1, 30'h3FFFFFFF, {30'h1234, 1'b1}, 0, 0, '0);
        @(negedge Clk);
        set_in(0, 0, '0, '0, 1, 0, 30'h999);
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_flush !== 1'b1) begin n_fail++; $display("FAIL wrap_flush got %b exp 1", o_flush); end
        n_cmp++; if (o_redirect_pc !== 30'h0) begin n_fail++; $display("FAIL wrap_redirect got %h exp 0", o_redirect_pc); end
        n_cmp++; if (o_next !== 1'b0) begin n_fail++; $display("FAIL wrap_next got %b exp 0", o_next); end
        n_cmp++; if (o_wr_data !== 30'h1234) begin n_fail++; $display("FAIL wrap_wr_data got %h exp 1234", o_wr_data); end
        n_cmp++; if (o_wr_addr !== 5'h1F) begin n_fail++; $display("FAIL wrap_wr_addr got %h exp 1f", o_wr_addr); end
        @(negedge Clk);
    endtask

    task automatic test_full();
        logic [29:0] pc;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pc = 30'h10 + 30'(i);
            set_in(1, 1, pc, {30'h40 + 30'(i), 1'b1}, 0, 0, '0);
            #1;
            n_cmp++; if (o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL full_fill_stall i=%0d got %b exp 0", i, o_fetch_stall); end
            @(negedge Clk);
        end
        set_in(1, 0, 30'h20, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL full_nonbranch_stall got %b exp 0", o_fetch_stall); end
        set_in(1, 1, 30'h14, {30'h44, 1'b1}, 1, 1, 30'h40);
        #1;
        n_cmp++; if (o_fetch_stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b exp 1", o_fetch_stall); end
        n_cmp++; if (o_res_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready got %b exp 1", o_res_ready); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_wr_addr !== 5'h10) begin n_fail++; $display("FAIL full_wr0 got %h exp 10", o_wr_addr); end
        @(negedge Clk);
        // Correct resolve with a same-cycle push keeps the occupancy at three.
        set_in(1, 1, 30'h14, {30'h44, 1'b1}, 1, 1, 30'h41);
        #1;
        n_cmp++; if (o_fetch_stall !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_stall got %b exp 0", o_fetch_stall); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_flush got %b exp 0", o_flush); end
        n_cmp++; if (o_wr_addr !== 5'h11) begin n_fail++; $display("FAIL full_wr1 got %h exp 11", o_wr_addr); end
        @(negedge Clk);
        for (int i = 2; i <= 4; i++) begin
            set_in(0, 0, '0, '0, 1, 1, 30'h40 + 30'(i));
            #1;
            n_cmp++; if (o_res_ready !== 1'b1) begin n_fail++; $display("FAIL full_drain_ready i=%0d got %b exp 1", i, o_res_ready); end
            @(negedge Clk);
            set_in(0, 0, '0, '0, 0, 0, '0);
            #1;
            n_cmp++; if (o_wr_addr !== 5'h10 + 5'(i)) begin n_fail++; $display("FAIL full_drain_addr i=%0d got %h exp %h", i, o_wr_addr, 5'h10 + 5'(i)); end
            n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL full_drain_flush i=%0d got %b exp 0", i, o_flush); end
            @(negedge Clk);
        end
        #1;
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b exp 0", o_res_ready); end
        @(negedge Clk);
    endtask

    task automatic test_empty_resolve();
        apply_reset();
        set_in(0, 0, '0, '0, 1, 1, 30'h123);
        #1;
        n_cmp++; if (o_res_ready !== 1'b0) begin n_fail++; $display("FAIL empty_ready got %b exp 0", o_res_ready); end
        @(negedge Clk);
        set_in(0, 0, '0, '0, 0, 0, '0);
        #1;
        n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL empty_we got %b exp 0", o_we); end
        n_cmp++; if (o_flush !== 1'b0) begin n_fail++; $display("FAIL empty_flush got %b exp 0", o_flush); end
`ifdef BRU_STATS_EN
        n_cmp++; if (o_br_count !== 16'd0) begin n_fail++; $display("FAIL empty_br_count got %0d exp 0", o_br_count); end
        n_cmp++; if (o_mispred_count !== 16'd0) begin n_fail++; $display("FAIL empty_mis_count got %0d exp 0", o_mispred_count); end
`endif
        @(negedge Clk);
    endtask

    typedef struct {
        logic [29:0] pc;
        logic [29:0] tgt;
        logic        tkn;
    } ent_t;

    task automatic test_random();
        ent_t        mq[$];
        ent_t        h, e;
        logic        m_upd = 0, m_flush = 0, m_we = 0, m_next = 0, mis;
        logic [29:0] m_redir = '0, m_wdata = '0;
        logic [4:0]  m_waddr = '0;
        int          m_br = 0, m_mis = 0;
        logic        e_stall, e_ready, fv, fb, rv, rtk, ptk;
        logic [4:0]  e_rd;
        logic [29:0] e_pn, pc, rtg, ptg;
        logic [31:0] r;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r   = $urandom;
            pc  = r[29:0];
            fv  = ($urandom_range(0, 3) != 0);
            fb  = ($urandom_range(0, 1) == 1);
            ptk = ($urandom_range(0, 1) == 1);
            ptg = ($urandom_range(0, 1) == 1) ? 30'h200 : 30'h300;
            rv  = ($urandom_range(0, 2) != 0);
            rtk = ($urandom_range(0, 1) == 1);
            rtg = ($urandom_range(0, 1) == 1) ? 30'h200 : 30'h300;
            set_in(fv, fb, pc, {ptg, ptk}, rv, rtk, rtg);
            #1;
            e_stall = m_upd || (mq.size() == DEPTH && fv && fb);
            e_ready = !m_upd && mq.size() > 0;
            e_rd    = m_upd ? m_waddr : pc[4:0];
            e_pn    = ptk ? ptg : pc + 30'd1;
            n_cmp++; if (o_fetch_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got %b exp %b", cyc, o_fetch_stall, e_stall); end
            n_cmp++; if (o_res_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b exp %b", cyc, o_res_ready, e_ready); end
            n_cmp++; if (o_rd_addr !== e_rd) begin n_fail++; $display("FAIL rnd_rd c=%0d got %h exp %h", cyc, o_rd_addr, e_rd); end
            n_cmp++; if (o_flush !== m_flush) begin n_fail++; $display("FAIL rnd_flush c=%0d got %b exp %b", cyc, o_flush, m_flush); end
            n_cmp++; if (o_we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d got %b exp %b", cyc, o_we, m_we); end
            if (!m_upd) begin
                n_cmp++; if (o_pred_next_pc !== e_pn) begin n_fail++; $display("FAIL rnd_pred c=%0d got %h exp %h", cyc, o_pred_next_pc, e_pn); end
            end
            if (m_we) begin
                n_cmp++; if (o_wr_addr !== m_waddr) begin n_fail++; $display("FAIL rnd_wr_addr c=%0d got %h exp %h", cyc, o_wr_addr, m_waddr); end
                n_cmp++; if (o_wr_data !== m_wdata) begin n_fail++; $display("FAIL rnd_wr_data c=%0d got %h exp %h", cyc, o_wr_data, m_wdata); end
                n_cmp++; if (o_next !== m_next) begin n_fail++; $display("FAIL rnd_next c=%0d got %b exp %b", cyc, o_next, m_next); end
            end
            if (m_flush) begin
                n_cmp++; if (o_redirect_pc !== m_redir) begin n_fail++; $display("FAIL rnd_redirect c=%0d got %h exp %h", cyc, o_redirect_pc, m_redir); end
            end
`ifdef BRU_STATS_EN
            n_cmp++; if (o_br_count !== 16'(m_br)) begin n_fail++; $display("FAIL rnd_br_count c=%0d got %0d exp %0d", cyc, o_br_count, m_br); end
            n_cmp++; if (o_mispred_count !== 16'(m_mis)) begin n_fail++; $display("FAIL rnd_mis_count c=%0d got %0d exp %0d", cyc, o_mispred_count, m_mis); end
`endif
            // Reference model advances across the rising edge.
            @(posedge Clk);
            m_flush = 0;
            m_we    = 0;
            mis     = 0;
            if (rv && e_ready) begin
                h = mq.pop_front();
                mis = (h.tkn != rtk) || (h.tkn && rtk && h.tgt != rtg);
                m_we = 1;
                m_waddr = h.pc[4:0];
                m_next = rtk;
                m_wdata = rtk ? rtg : h.tgt;
                m_br++;
                if (mis) begin
                    m_flush = 1;
                    m_redir = rtk ? rtg : h.pc + 30'd1;
                    mq.delete();
                    m_mis++;
                end
                m_upd = 1;
            end else begin
                m_upd = 0;
            end
            if (fv && fb && !e_stall && !mis) begin
                e.pc = pc; e.tgt = ptg; e.tkn = ptk;
                mq.push_back(e);
            end
            @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_mispredict();
        test_wrap();
        test_full();
        test_empty_resolve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
